uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 240 ++++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_fifo
//  Purpose  : UART receiver with a line synchronizer, glitch-rejecting start
//             detection, optional parity and 1/2 stop bits. Received frames
//             land in a first-word-fall-through FIFO with per-entry parity
//             and framing error flags and a sticky overrun flag.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 27_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_pin,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_parity_err,
  output logic                          rd_frame_err,
  output logic                          rd_valid,
  input  logic                          rd_en,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  input  logic                          clear_overrun
);

  // Baud timing: one full bit is c_CYCLE clocks, the start bit is qualified
  // for c_HALF clocks so every later sample lands mid-bit.
  localparam int c_CYCLE = CLK_FREQ / BAUD_RATE;
  localparam int c_HALF  = c_CYCLE / 2;
  localparam int c_TW    = $clog2(c_CYCLE) + 1;
  localparam int c_AW    = $clog2(FIFO_DEPTH);
  localparam int c_BW    = 4;

  localparam logic [c_TW-1:0] c_CYCLE_M1  = c_TW'(c_CYCLE - 1);
  localparam logic [c_TW-1:0] c_HALF_M1   = c_TW'(c_HALF - 1);
  localparam logic [c_BW-1:0] c_DATA_LAST = c_BW'(DATA_BITS - 1);
  localparam logic [c_BW-1:0] c_STOP_LAST = c_BW'(STOP_BITS - 1);
  localparam logic [c_AW:0]   c_DEPTH     = (c_AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_sync1;
  logic                   r_sync2;
  logic [c_TW-1:0]        r_timer;
  logic [c_BW-1:0]        r_bitcnt;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_parity_err;
  logic                   r_frame_err;

  logic                   w_rx;
  logic                   w_tick;
  logic                   w_half;
  logic                   w_last_data;
  logic                   w_last_stop;
  logic                   w_push;
  logic                   w_frame_err;
  logic                   w_xor;
  logic                   w_par_bad;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0]   r_mem_data [FIFO_DEPTH];
  logic                   r_mem_perr [FIFO_DEPTH];
  logic                   r_mem_ferr [FIFO_DEPTH];
  logic [c_AW-1:0]        r_wr_ptr;
  logic [c_AW-1:0]        r_rd_ptr;
  logic [c_AW:0]          r_count;
  logic                   r_overrun;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_pop;
  logic                   w_wr;
  logic                   w_ovf;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_pin;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx        = r_sync2;
  assign w_tick      = (r_timer == c_CYCLE_M1);
  assign w_half      = (r_timer == c_HALF_M1);
  assign w_last_data = (r_bitcnt == c_DATA_LAST);
  assign w_last_stop = (r_bitcnt == c_STOP_LAST);
  assign w_push      = (r_state == S_STOP) && w_tick && w_last_stop;
  // Error of the frame being closed, including the stop sample taken now.
  assign w_frame_err = r_frame_err | ~w_rx;
  assign w_xor       = (^r_shift) ^ w_rx;
  assign w_par_bad   = (PARITY == 1) ? ~w_xor : w_xor;

  // Receiver state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Receiver next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_rx) w_state_nxt = S_START;
      end
      S_START: begin
        if (w_rx)        w_state_nxt = S_IDLE;
        else if (w_half) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (w_tick && w_last_data) w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (w_tick) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (w_push) w_state_nxt = w_frame_err ? S_BREAK : S_IDLE;
      end
      S_BREAK: begin
        if (w_rx) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bit timer, bit counter, data shift register and error accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer      <= '0;
      r_bitcnt     <= '0;
      r_shift      <= '0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      case (r_state)
        S_START: begin
          r_timer <= w_half ? '0 : r_timer + 1'b1;
        end
        S_DATA: begin
          r_timer <= w_tick ? '0 : r_timer + 1'b1;
          if (w_tick) begin
            r_shift  <= {w_rx, r_shift[DATA_BITS-1:1]};
            r_bitcnt <= w_last_data ? '0 : r_bitcnt + 1'b1;
          end
        end
        S_PARITY: begin
          r_timer <= w_tick ? '0 : r_timer + 1'b1;
          if (w_tick) r_parity_err <= w_par_bad;
        end
        S_STOP: begin
          r_timer <= w_tick ? '0 : r_timer + 1'b1;
          if (w_tick) begin
            r_frame_err <= w_frame_err;
            r_bitcnt    <= r_bitcnt + 1'b1;
          end
        end
        default: begin
          // IDLE and BREAK: nothing in flight, prepare a clean frame.
          r_timer      <= '0;
          r_bitcnt     <= '0;
          r_parity_err <= 1'b0;
          r_frame_err  <= 1'b0;
        end
      endcase
    end
  end

  assign w_full  = (r_count == c_DEPTH);
  assign w_empty = (r_count == '0);
  assign w_pop   = rd_en && !w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_wr    = w_push && (!w_full || w_pop);
  assign w_ovf   = w_push && w_full && !w_pop;

  // FIFO entry write; storage needs no reset because outputs are gated.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem_data[r_wr_ptr] <= r_shift;
      r_mem_perr[r_wr_ptr] <= r_parity_err;
      r_mem_ferr[r_wr_ptr] <= w_frame_err;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overrun flag; a new overrun wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else if (w_ovf) begin
      r_overrun <= 1'b1;
    end else if (clear_overrun) begin
      r_overrun <= 1'b0;
    end
  end

  assign rd_valid      = !w_empty;
  assign rd_data       = rd_valid ? r_mem_data[r_rd_ptr] : '0;
  assign rd_parity_err = rd_valid ? r_mem_perr[r_rd_ptr] : 1'b0;
  assign rd_frame_err  = rd_valid ? r_mem_ferr[r_rd_ptr] : 1'b0;
  assign fifo_count    = r_count;
  assign overrun       = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_fifo
//  Purpose  : Self-checking bench for uart_rx_fifo: an 8N1 instance and an
//             8E1 instance driven by a bit-level serial transmitter, checked
//             against directed expectations and a queue-based frame model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

  localparam int CYC = 234;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx0, rx2;
  logic       rd0, rd2, clr0, clr2;
  logic [7:0] d0, d2;
  logic       pe0, fe0, v0, ov0;
  logic       pe2, fe2, v2, ov2;
  logic [4:0] cnt0, cnt2;

  int   n_cmp  = 0;
  int   n_fail = 0;
  ent_t q0[$];
  ent_t q2[$];

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLK_FREQ(27_000_000), .BAUD_RATE(115200), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)
  ) u_dut0 (
    .clk(clk), .rst(rst), .rx_pin(rx0),
    .rd_data(d0), .rd_parity_err(pe0), .rd_frame_err(fe0), .rd_valid(v0),
    .rd_en(rd0), .fifo_count(cnt0), .overrun(ov0), .clear_overrun(clr0)
  );

  uart_rx_fifo #(
    .CLK_FREQ(27_000_000), .BAUD_RATE(115200), .DATA_BITS(8),
    .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)
  ) u_dut2 (
    .clk(clk), .rst(rst), .rx_pin(rx2),
    .rd_data(d2), .rd_parity_err(pe2), .rd_frame_err(fe2), .rd_valid(v2),
    .rd_en(rd2), .fifo_count(cnt2), .overrun(ov2), .clear_overrun(clr2)
  );

  // Even parity is violated when the total number of ones is odd.
  function automatic logic even_par_bad(input logic [7:0] data, input logic pbit);
    return ($countones({data, pbit}) % 2) != 0;
  endfunction

  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_time();
    clocks(CYC);
  endtask

  task automatic tx0(input logic [7:0] data, input logic stop);
    rx0 = 1'b0; bit_time();
    for (int i = 0; i < 8; i++) begin rx0 = data[i]; bit_time(); end
    rx0 = stop; bit_time();
    rx0 = 1'b1;
  endtask

  task automatic tx2(input logic [7:0] data, input logic pbit, input logic stop);
    rx2 = 1'b0; bit_time();
    for (int i = 0; i < 8; i++) begin rx2 = data[i]; bit_time(); end
    rx2 = pbit; bit_time();
    rx2 = stop; bit_time();
    rx2 = 1'b1;
  endtask

  task automatic pop0();
    rd0 = 1'b1; clocks(1); rd0 = 1'b0;
  endtask

  task automatic pop2();
    rd2 = 1'b1; clocks(1); rd2 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx0 = 1'b1; rx2 = 1'b1;
    rd0 = 1'b0; rd2 = 1'b0; clr0 = 1'b0; clr2 = 1'b0;
    clocks(5);
    n_cmp++;
    if ({v0, d0, pe0, fe0, cnt0, ov0} !== 16'h0) begin
      n_fail++; $display("FAIL reset_dut0: got %h want 0", {v0, d0, pe0, fe0, cnt0, ov0});
    end
    n_cmp++;
    if ({v2, d2, pe2, fe2, cnt2, ov2} !== 16'h0) begin
      n_fail++; $display("FAIL reset_dut2: got %h want 0", {v2, d2, pe2, fe2, cnt2, ov2});
    end
    rst = 1'b0;
    clocks(20);
    n_cmp++;
    if ({v0, cnt0, ov0} !== 7'h0) begin
      n_fail++; $display("FAIL reset_release: got v=%b cnt=%0d ov=%b want 0", v0, cnt0, ov0);
    end
  endtask

  task automatic test_8n1();
    tx0(8'hA5, 1'b1);
    n_cmp++;
    if ({v0, d0, pe0, fe0} !== {1'b1, 8'hA5, 2'b00}) begin
      n_fail++; $display("FAIL 8n1_head: got v=%b d=%h pe=%b fe=%b want 1 a5 0 0", v0, d0, pe0, fe0);
    end
    n_cmp++;
    if (cnt0 !== 5'd1) begin
      n_fail++; $display("FAIL 8n1_count: got %0d want 1", cnt0);
    end
    pop0();
    n_cmp++;
    if (v0 !== 1'b0) begin
      n_fail++; $display("FAIL 8n1_pop: rd_valid got %b want 0", v0);
    end
  endtask

  task automatic test_parity();
    tx2(8'h03, 1'b1, 1'b1);
    n_cmp++;
    if ({cnt2, d2, pe2, fe2} !== {5'd1, 8'h03, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL parity_err: got cnt=%0d d=%h pe=%b fe=%b want 1 03 1 0", cnt2, d2, pe2, fe2);
    end
    pop2();
    n_cmp++;
    if (v2 !== 1'b0) begin
      n_fail++; $display("FAIL parity_pop: rd_valid got %b want 0", v2);
    end
  endtask

  task automatic test_break();
    rx0 = 1'b0;
    repeat (20) bit_time();
    n_cmp++;
    if (cnt0 !== 5'd1) begin
      n_fail++; $display("FAIL break_one_entry: count got %0d want 1", cnt0);
    end
    rx0 = 1'b1; bit_time();
    tx0(8'h5A, 1'b1);
    n_cmp++;
    if (cnt0 !== 5'd2) begin
      n_fail++; $display("FAIL break_count: got %0d want 2", cnt0);
    end
    n_cmp++;
    if ({d0, pe0, fe0} !== {8'h00, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL break_entry: got d=%h pe=%b fe=%b want 00 0 1", d0, pe0, fe0);
    end
    pop0();
    n_cmp++;
    if ({v0, d0, pe0, fe0} !== {1'b1, 8'h5A, 2'b00}) begin
      n_fail++; $display("FAIL break_next: got v=%b d=%h pe=%b fe=%b want 1 5a 0 0", v0, d0, pe0, fe0);
    end
    pop0();
  endtask

  task automatic test_glitch();
    rx0 = 1'b0; clocks(50);
    rx0 = 1'b1; bit_time(); bit_time();
    n_cmp++;
    if ({v0, cnt0} !== 6'h0) begin
      n_fail++; $display("FAIL glitch: got v=%b cnt=%0d want 0 0", v0, cnt0);
    end
  endtask

  task automatic test_overrun();
    for (int i = 1; i <= 17; i++) tx0(8'(i), 1'b1);
    n_cmp++;
    if ({cnt0, ov0} !== {5'd16, 1'b1}) begin
      n_fail++; $display("FAIL overrun_full: got cnt=%0d ov=%b want 16 1", cnt0, ov0);
    end
    for (int k = 1; k <= 16; k++) begin
      n_cmp++;
      if ({v0, d0} !== {1'b1, 8'(k)}) begin
        n_fail++; $display("FAIL overrun_pop%0d: got v=%b d=%h want 1 %h", k, v0, d0, 8'(k));
      end
      pop0();
    end
    n_cmp++;
    if ({v0, ov0} !== 2'b01) begin
      n_fail++; $display("FAIL overrun_sticky: got v=%b ov=%b want 0 1", v0, ov0);
    end
    clr0 = 1'b1; clocks(1); clr0 = 1'b0;
    n_cmp++;
    if (ov0 !== 1'b0) begin
      n_fail++; $display("FAIL overrun_clear: got %b want 0", ov0);
    end
  endtask

  task automatic test_reset_midframe();
    tx0(8'h77, 1'b1);
    rx0 = 1'b0; bit_time();
    rx0 = 1'b0; bit_time(); bit_time(); bit_time();
    rx0 = 1'b1; clocks(100);
    rst = 1'b1; clocks(3);
    n_cmp++;
    if ({v0, d0, pe0, fe0, cnt0, ov0} !== 16'h0) begin
      n_fail++; $display("FAIL midframe_reset: got %h want 0", {v0, d0, pe0, fe0, cnt0, ov0});
    end
    rst = 1'b0;
    bit_time(); bit_time();
    n_cmp++;
    if (cnt0 !== 5'd0) begin
      n_fail++; $display("FAIL midframe_discard: count got %0d want 0", cnt0);
    end
    tx0(8'hC3, 1'b1);
    n_cmp++;
    if ({cnt0, d0, pe0, fe0} !== {5'd1, 8'hC3, 2'b00}) begin
      n_fail++; $display("FAIL midframe_resume: got cnt=%0d d=%h pe=%b fe=%b want 1 c3 0 0", cnt0, d0, pe0, fe0);
    end
    pop0();
  endtask

  task automatic test_random();
    q0.delete(); q2.delete();
    fork
      begin
        for (int n = 0; n < 5; n++) begin
          logic [7:0] d; logic s; ent_t e;
          d = 8'($urandom); s = ($urandom_range(0, 3) != 0);
          tx0(d, s);
          e.d = d; e.pe = 1'b0; e.fe = ~s; q0.push_back(e);
          if (!s) bit_time();
        end
      end
      begin
        for (int n = 0; n < 5; n++) begin
          logic [7:0] d; logic p; logic s; ent_t e;
          d = 8'($urandom); p = 1'($urandom); s = ($urandom_range(0, 3) != 0);
          tx2(d, p, s);
          e.d = d; e.pe = even_par_bad(d, p); e.fe = ~s; q2.push_back(e);
          if (!s) bit_time();
        end
      end
    join
    n_cmp++;
    if (cnt0 !== 5'(q0.size())) begin
      n_fail++; $display("FAIL rand_count0: got %0d want %0d", cnt0, q0.size());
    end
    n_cmp++;
    if (cnt2 !== 5'(q2.size())) begin
      n_fail++; $display("FAIL rand_count2: got %0d want %0d", cnt2, q2.size());
    end
    while (q0.size() > 0) begin
      ent_t e;
      e = q0.pop_front();
      n_cmp++;
      if ({v0, d0, pe0, fe0} !== {1'b1, e.d, e.pe, e.fe}) begin
        n_fail++; $display("FAIL rand_entry0: got v=%b d=%h pe=%b fe=%b want 1 %h %b %b", v0, d0, pe0, fe0, e.d, e.pe, e.fe);
      end
      pop0();
    end
    while (q2.size() > 0) begin
      ent_t e;
      e = q2.pop_front();
      n_cmp++;
      if ({v2, d2, pe2, fe2} !== {1'b1, e.d, e.pe, e.fe}) begin
        n_fail++; $display("FAIL rand_entry2: got v=%b d=%h pe=%b fe=%b want 1 %h %b %b", v2, d2, pe2, fe2, e.d, e.pe, e.fe);
      end
      pop2();
    end
    n_cmp++;
    if ({v0, v2} !== 2'b00) begin
      n_fail++; $display("FAIL rand_drained: got v0=%b v2=%b want 0 0", v0, v2);
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_break();
    test_glitch();
    test_overrun();
    test_reset_midframe();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
